// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Read-side drain engine for the 16-entry FIFO controller/RAM pair. A start
// command pops a programmed number of words from the FIFO and presents them on
// a valid/ready stream. It sustains one word per cycle while the FIFO is
// non-empty and the sink is ready.
//
// Optional feature (compile-time macro FIFO_RD_TIMEOUT_EN):
//   When defined, a burst that waits in FETCH on an empty FIFO for TIMEOUT_CYC
//   cycles is aborted. oTimeout and oDone then pulse together, and oRemain
//   keeps the unpopped count. When undefined, FETCH waits indefinitely and
//   oTimeout is always 0.
//
// Ports:
//   iClk        clock, rising edge
//   iRst        asynchronous, active-high reset
//   iStart      burst start request, sampled in IDLE only
//   iLen        words to drain (LEN_W), sampled with iStart
//   oBusy       high in any state other than IDLE
//   oDone       one-cycle pulse at end of burst
//   oRemain     words not yet popped in the current burst (LEN_W)
//   iFifoEmpty  FIFO empty flag
//   oFifoPop    pop strobe to FIFO, combinational from state and inputs
//   iFifoRdata  FIFO word at current read pointer (DATA_W)
//   oValid      output word valid
//   oData       output word, registered (DATA_W)
//   iReady      sink accepts oData when oValid && iReady
//   oTimeout    one-cycle pulse on empty-wait abort
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned LEN_W       = 5,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iStart,
   input  logic [LEN_W-1:0]  iLen,
   output logic              oBusy,
   output logic              oDone,
   output logic [LEN_W-1:0]  oRemain,
   input  logic              iFifoEmpty,
   output logic              oFifoPop,
   input  logic [DATA_W-1:0] iFifoRdata,
   output logic              oValid,
   output logic [DATA_W-1:0] oData,
   input  logic              iReady,
   output logic              oTimeout
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   remain_q, remain_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               timeout_q, timeout_d;
   logic               pop;
   logic               fetch_expire;

`ifdef FIFO_RD_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   // Expires on the cycle the count would reach TIMEOUT_CYC, so exactly
   // TIMEOUT_CYC empty FETCH cycles elapse before DONE.
   assign fetch_expire = (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_comb begin
      wait_cnt_d = '0;
      if (state_q == ST_FETCH && iFifoEmpty && !fetch_expire) begin
         wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end
`else
   logic unused_timeout_cfg;

   assign fetch_expire       = 1'b0;
   assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

   always_comb begin
      state_d   = state_q;
      remain_d  = remain_q;
      data_d    = data_q;
      timeout_d = 1'b0;
      pop       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (iStart) begin
               remain_d = iLen;
               state_d  = (iLen != '0) ? ST_FETCH : ST_DONE;
            end
         end

         ST_FETCH: begin
            if (!iFifoEmpty) begin
               pop      = 1'b1;
               data_d   = iFifoRdata;
               remain_d = remain_q - LEN_W'(1);
               state_d  = ST_SEND;
            end else if (fetch_expire) begin
               timeout_d = 1'b1;
               state_d   = ST_DONE;
            end
         end

         ST_SEND: begin
            if (iReady) begin
               if (remain_q == '0) begin
                  state_d = ST_DONE;
               end else if (!iFifoEmpty) begin
                  // Pop and reload in the accept cycle for back-to-back words.
                  pop      = 1'b1;
                  data_d   = iFifoRdata;
                  remain_d = remain_q - LEN_W'(1);
               end else begin
                  state_d = ST_FETCH;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status outputs are registered from the next state, so they line up
      // with state_q without decode glitches.
      valid_d = (state_d == ST_SEND);
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q   <= ST_IDLE;
         remain_q  <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         remain_q  <= remain_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
      end
   end

   assign oFifoPop = pop;
   assign oRemain  = remain_q;
   assign oData    = data_q;
   assign oValid   = valid_q;
   assign oBusy    = busy_q;
   assign oDone    = done_q;
   assign oTimeout = timeout_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

   logic       clk;
   logic       rst;
   logic       start;
   logic [4:0] len;
   logic       busy;
   logic       done;
   logic [4:0] remain;
   logic       fifo_empty;
   logic       fifo_pop;
   logic [7:0] fifo_rdata;
   logic       valid;
   logic [7:0] data;
   logic       ready;
   logic       tmo;

   int checks   = 0;
   int failures = 0;

   // FIFO model: pushes come from the stimulus, pops from the DUT strobe.
   logic [7:0] mem [64];
   logic [5:0] wr_ptr = '0;
   logic [5:0] rd_ptr = '0;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_rdata = mem[rd_ptr];

   always @(posedge clk) begin
      if (fifo_pop) rd_ptr <= rd_ptr + 6'd1;
   end

   fifo_rd_stream #(
      .DATA_W     (8),
      .LEN_W      (5),
      .TIMEOUT_CYC(16)
   ) dut (
      .iClk      (clk),
      .iRst      (rst),
      .iStart    (start),
      .iLen      (len),
      .oBusy     (busy),
      .oDone     (done),
      .oRemain   (remain),
      .iFifoEmpty(fifo_empty),
      .oFifoPop  (fifo_pop),
      .iFifoRdata(fifo_rdata),
      .oValid    (valid),
      .oData     (data),
      .iReady    (ready),
      .oTimeout  (tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Scoreboard of words the sink should receive, in order.
   logic [7:0] exp_q [$];
   int pop_cnt  = 0;
   int done_cnt = 0;
   int acc_cnt  = 0;

   task automatic push(input logic [7:0] w);
      mem[wr_ptr] = w;
      wr_ptr      = wr_ptr + 6'd1;
      exp_q.push_back(w);
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = '0;
   always @(negedge clk) begin
      logic [7:0] e;
      if (fifo_pop) begin
         pop_cnt++;
         chk("pop_while_empty", fifo_empty, 1'b0);
      end
      if (done) done_cnt++;
`ifndef FIFO_RD_TIMEOUT_EN
      if (tmo) chk("timeout_disabled", tmo, 1'b0);
`endif
      if (prev_stall && !rst) begin
         chk("stall_valid_hold", valid, 1'b1);
         chk("stall_data_hold", data, prev_data);
      end
      if (valid && !ready) chk("stall_no_pop", fifo_pop, 1'b0);
      if (valid && ready) begin
         acc_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_word", data, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("stream_data", data, e);
         end
      end
      prev_stall = valid && !ready;
      prev_data  = data;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0]  pop_m, val_m, done_m;
      int          p0, d0, a0;
      rst   = 1'b1;
      start = 1'b0;
      len   = '0;
      ready = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_valid", valid, 0);
      chk("rst_data", data, 0);
      chk("rst_remain", remain, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_timeout", tmo, 0);
      chk("rst_pop", fifo_pop, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // T1: 4 preloaded words, sink always ready
      for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
      pop_m  = 8'b0001_1110;
      val_m  = 8'b0011_1100;
      done_m = 8'b0100_0000;
      p0 = pop_cnt;
      d0 = done_cnt;
      for (int c = 0; c < 8; c++) begin
         start = (c == 0);
         len   = 5'd4;
         @(negedge clk);
         chk("t1_pop", fifo_pop, pop_m[c]);
         chk("t1_valid", valid, val_m[c]);
         chk("t1_done", done, done_m[c]);
         @(posedge clk); #1;
      end
      chk("t1_pops", pop_cnt - p0, 4);
      chk("t1_done_cnt", done_cnt - d0, 1);
      chk("t1_drained", exp_q.size(), 0);

      // T2: 3 words, ready toggling every cycle
      for (int i = 0; i < 3; i++) push(8'hB0 + 8'(i));
      p0 = pop_cnt;
      d0 = done_cnt;
      for (int c = 0; c < 30; c++) begin
         start = (c == 0);
         len   = 5'd3;
         ready = (c % 2) == 1;
         @(posedge clk); #1;
         if (done_cnt != d0) break;
      end
      start = 1'b0;
      ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("t2_done_cnt", done_cnt - d0, 1);
      chk("t2_pops", pop_cnt - p0, 3);
      chk("t2_drained", exp_q.size(), 0);

      // T3: empty FIFO, words arrive at cycles 10 and 20
      p0 = pop_cnt;
      for (int c = 0; c < 24; c++) begin
         start = (c == 0);
         len   = 5'd2;
         if (c == 10) push(8'h31);
         if (c == 20) push(8'h32);
         @(negedge clk);
         if (c >= 1) begin
            chk("t3_remain", remain, (c <= 10) ? 2 : (c <= 20) ? 1 : 0);
            chk("t3_pop", fifo_pop, (c == 10 || c == 20) ? 1 : 0);
            chk("t3_done", done, (c == 22) ? 1 : 0);
         end
         @(posedge clk); #1;
      end
      chk("t3_pops", pop_cnt - p0, 2);
      chk("t3_drained", exp_q.size(), 0);

      // T4: zero-length burst, second start while busy ignored
      p0 = pop_cnt;
      for (int c = 0; c < 4; c++) begin
         start = (c == 0 || c == 1);
         len   = (c == 0) ? 5'd0 : 5'd3;
         @(negedge clk);
         if (c >= 1) begin
            chk("t4_busy", busy, (c == 1) ? 1 : 0);
            chk("t4_done", done, (c == 1) ? 1 : 0);
            chk("t4_remain", remain, 0);
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk("t4_pops", pop_cnt - p0, 0);

      // T5: reset mid-burst after 3 words accepted
      for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
      p0 = pop_cnt;
      a0 = acc_cnt;
      for (int c = 0; c < 5; c++) begin
         start = (c == 0);
         len   = 5'd8;
         @(negedge clk);
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk("t5_accepted", acc_cnt - a0, 3);
      chk("t5_pops", pop_cnt - p0, 4);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_rst_valid", valid, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_remain", remain, 0);
      chk("t5_rst_pop", fifo_pop, 0);
      // C3 was popped and lost; C4..C7 remain in the FIFO.
      exp_q.delete();
      for (int i = 4; i < 8; i++) exp_q.push_back(8'hC0 + 8'(i));
      @(posedge clk); #1;
      rst = 1'b0;
      push(8'hD0);
      push(8'hD1);
      @(negedge clk);
      chk("t5_post_busy", busy, 0);
      chk("t5_post_valid", valid, 0);
      @(posedge clk); #1;
      p0 = pop_cnt;
      d0 = done_cnt;
      for (int c = 0; c < 30; c++) begin
         start = (c == 0);
         len   = 5'd6;
         @(posedge clk); #1;
         if (done_cnt != d0) break;
      end
      start = 1'b0;
      chk("t5_new_done", done_cnt - d0, 1);
      chk("t5_new_pops", pop_cnt - p0, 6);
      chk("t5_new_drained", exp_q.size(), 0);

`ifdef FIFO_RD_TIMEOUT_EN
      // T6: empty-wait abort after 16 FETCH cycles
      p0 = pop_cnt;
      for (int c = 0; c < 19; c++) begin
         start = (c == 0);
         len   = 5'd5;
         @(negedge clk);
         if (c >= 1) begin
            chk("t6_done", done, (c == 17) ? 1 : 0);
            chk("t6_timeout", tmo, (c == 17) ? 1 : 0);
            chk("t6_remain", remain, 5);
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk("t6_pops", pop_cnt - p0, 0);
`endif

      repeat (2) @(posedge clk);
      #1;
      chk("final_scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side drain engine for the 16-entry FIFO controller/RAM pair. On a start command it pops a programmed number of words from the FIFO and presents them on a valid/ready output stream, one word per cycle when the FIFO is non-empty and the sink is ready. It sits between the FIFO (oEmpty flag, combinational read data at the current read address) and downstream consumers such as the UART TX path.

Parameters:
DATA_W, 8, width of FIFO words and stream data
LEN_W, 5, width of burst length; bursts of 1..2^LEN_W-1 words, may exceed FIFO depth while the producer refills
TIMEOUT_CYC, 255, empty-wait limit in cycles; used only with FIFO_RD_TIMEOUT_EN

Ports:
iClk  in  1  clock, rising edge
iRst  in  1  asynchronous, active-high reset
iStart  in  1  burst start request, sampled in IDLE only
iLen  in  LEN_W  words to drain, sampled with iStart
oBusy  out  1  high in any state other than IDLE
oDone  out  1  one-cycle pulse at end of burst
oRemain  out  LEN_W  words not yet popped in current burst
iFifoEmpty  in  1  FIFO empty flag
oFifoPop  out  1  pop strobe to FIFO (combinational from state)
iFifoRdata  in  DATA_W  FIFO word at current read pointer, valid when !iFifoEmpty
oValid  out  1  output word valid
oData  out  DATA_W  output word (registered)
iReady  in  1  sink accepts oData when oValid&&iReady
oTimeout  out  1  one-cycle pulse on empty-wait abort (0 when feature disabled)

Behaviour:
- Reset: state IDLE; oValid=0, oData=0, oRemain=0, oBusy=0, oDone=0, oTimeout=0, oFifoPop=0. Reset mid-burst abandons the burst; words already popped are lost; FIFO pointers are not touched by this block.
- States: IDLE, FETCH, SEND, DONE.
- IDLE: oValid=0. iStart=1 with iLen!=0 -> rRemain<=iLen, go to FETCH. iStart=1 with iLen==0 -> go to DONE (no pops). iStart in any state other than IDLE is ignored.
- FETCH: oValid=0. If !iFifoEmpty: oFifoPop=1, oData<=iFifoRdata, rRemain<=rRemain-1, go to SEND. Else stay in FETCH with no pop.
- SEND: oValid=1; oData and oValid hold stable while !iReady.
  - On iReady with rRemain==0 -> go to DONE.
  - On iReady with rRemain!=0 and !iFifoEmpty: pop and load in the same cycle, decrement, stay in SEND. This gives back-to-back throughput of 1 word/cycle.
  - On iReady with rRemain!=0 and iFifoEmpty -> go to FETCH.
- DONE: oDone=1 for exactly one cycle, oValid=0, then go to IDLE.
- oFifoPop is never asserted while iFifoEmpty=1. At most one pop per cycle. The total number of pops per burst equals iLen exactly.
- Latency: iStart at cycle 0 with a non-empty FIFO -> pop at cycle 1 -> oValid=1 at cycle 2. With iReady held high, the last word is accepted at cycle iLen+1 and oDone is high at cycle iLen+2.
- oRemain is the registered rRemain and decrements on each pop. Its wrap-around is impossible because popping is gated by rRemain!=0.

Optional Feature:
FIFO_RD_TIMEOUT_EN: when defined, a counter of width clog2(TIMEOUT_CYC+1) increments every cycle spent in FETCH with iFifoEmpty=1. It clears on a pop or on leaving FETCH. When the count reaches TIMEOUT_CYC, the block goes to DONE; oTimeout and oDone pulse together in that DONE cycle, and oRemain keeps the unpopped count. When not defined, FETCH waits indefinitely, no counter is built, and oTimeout is tied to 0.

Test Plan:
- Preload 4 words A0..A3, iStart with iLen=4, iReady=1 -> pops in cycles 1-4; oValid=1 cycles 2-5 with data A0..A3; oDone pulse at cycle 6; exactly 4 pops.
- Preload 3 words, iLen=3, iReady toggled 1/0 each cycle -> oData held stable while iReady=0; no pop while a word is stalled; sequence order preserved; oDone once.
- Empty FIFO, iLen=2; push one word at cycle 10 and another at cycle 20 -> FETCH waits with oFifoPop=0; two words delivered; oRemain steps 2->1->0.
- iStart with iLen=0 -> no pops; oDone pulse one cycle later; oBusy high for one cycle. A second iStart while busy is ignored.
- Assert iRst mid-burst (iLen=8, after 3 words accepted) -> next cycle oValid=0, oBusy=0, oRemain=0; a new burst runs correctly afterwards.
- With FIFO_RD_TIMEOUT_EN, TIMEOUT_CYC=16, empty FIFO, iLen=5 -> oTimeout and oDone pulse together after 16 FETCH cycles; oRemain=5; no pops.
